// File: rtl/jk_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_pkg : JK excitation encodings and the present/next -> {j,k} map. Rev 1.0
// ---------------------------------------------------------------------------
package jk_pkg;

  localparam logic [1:0] JK_HOLD   = 2'b00;
  localparam logic [1:0] JK_RESET  = 2'b01;
  localparam logic [1:0] JK_SET    = 2'b10;
  localparam logic [1:0] JK_TOGGLE = 2'b11;

  // Toggle is deliberately never produced: 1->1 holds, so the bank cannot
  // run away if it ever samples an excitation twice.
  function automatic logic [1:0] jk_excite(input logic present, input logic next);
    logic [1:0] pair;
    case ({present, next})
      2'b01:   pair = JK_SET;
      2'b10:   pair = JK_RESET;
      default: pair = JK_HOLD;
    endcase
    return pair;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_n_next.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mod_n_next : combinational mod-N next state (load clamp, up/down, wrap). Rev 1.0
// ---------------------------------------------------------------------------
module mod_n_next #(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic [WIDTH-1:0] count,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] nxt
);

  // One extra bit so MODULUS == 2^WIDTH is representable in the compares.
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0] MOD_M1  = WIDTH'(MODULUS - 1);

  always_comb begin
    nxt = count;
    if (load) begin
      nxt = ({1'b0, load_val} < MOD_EXT) ? load_val : '0;
    end else if (en) begin
      if (up) begin
        nxt = ({1'b0, count} == (MOD_EXT - 1'b1)) ? '0 : count + 1'b1;
      end else begin
        nxt = (count == '0) ? MOD_M1 : count - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/jk_excitation_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// jk_excitation_counter : shadow mod-N counter emitting J/K excitation for an
// external JK bank, with a sticky Q-feedback divergence flag. Rev 1.0
// ---------------------------------------------------------------------------
module jk_excitation_counter
  import jk_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] q_fb,
  input  logic             mismatch_clr,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             mismatch
);

  localparam logic [WIDTH-1:0] MOD_M1 = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] nxt;
  logic             mismatch_q, mismatch_d;

  mod_n_next #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_next (
    .count    (count_q),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .nxt      (nxt)
  );

  always_comb begin
    count_d    = nxt;
    mismatch_d = mismatch_q;
    if (q_fb != count_q) begin
      mismatch_d = 1'b1;
    end else if (mismatch_clr) begin
      mismatch_d = 1'b0;
    end
    if (reset) begin
      count_d    = '0;
      mismatch_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    count_q    <= count_d;
    mismatch_q <= mismatch_d;
  end

  // During reset every bank bit gets K=1 so it clears on the same edge as count_q.
  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = jk_excite(count_q[i], nxt[i]);
    end
    if (reset) begin
      j = '0;
      k = '1;
    end
  end

  assign tc       = en & ~load & ((up & (count_q == MOD_M1)) | (~up & (count_q == '0)));
  assign count    = count_q;
  assign mismatch = mismatch_q;

endmodule
`default_nettype wire

// File: tb/tb_jk_excitation_counter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_jk_excitation_counter : two counters (mod 10 and mod 16) each driving a
// behavioural JK bank, checked against an arithmetic reference model. Rev 1.0
// ---------------------------------------------------------------------------
module tb_jk_excitation_counter;
  import jk_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1, en = 1'b0, up = 1'b0, load = 1'b0, mismatch_clr = 1'b0;
  logic [3:0] load_val = 4'd0;
  logic [3:0] fault = 4'd0;

  logic [3:0] bank [2] = '{4'b1010, 4'b0110};
  logic [3:0] q_fb [2];
  logic [3:0] j [2];
  logic [3:0] k [2];
  logic [3:0] count [2];
  logic       tc [2];
  logic       mismatch [2];

  assign q_fb[0] = bank[0] ^ fault;
  assign q_fb[1] = bank[1];

  jk_excitation_counter #(.WIDTH(4), .MODULUS(10)) dut (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q_fb(q_fb[0]), .mismatch_clr(mismatch_clr), .j(j[0]), .k(k[0]),
    .count(count[0]), .tc(tc[0]), .mismatch(mismatch[0])
  );

  jk_excitation_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
    .clk(clk), .reset(reset), .en(en), .up(up), .load(load), .load_val(load_val),
    .q_fb(q_fb[1]), .mismatch_clr(mismatch_clr), .j(j[1]), .k(k[1]),
    .count(count[1]), .tc(tc[1]), .mismatch(mismatch[1])
  );

  // Behavioural JK bank: it only ever changes through the J/K it is given.
  function automatic logic [3:0] jk_step(input logic [3:0] q, input logic [3:0] jj,
                                         input logic [3:0] kk);
    logic [3:0] n;
    n = q;
    for (int i = 0; i < 4; i++) begin
      case ({jj[i], kk[i]})
        JK_SET:    n[i] = 1'b1;
        JK_RESET:  n[i] = 1'b0;
        JK_TOGGLE: n[i] = ~q[i];
        default:   n[i] = q[i];
      endcase
    end
    return n;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) bank[d] <= jk_step(bank[d], j[d], k[d]);
  end

  int mods [2] = '{10, 16};
  int cm [2]   = '{0, 0};
  bit mm [2]   = '{1'b0, 1'b0};
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_next(input int d, input logic e, input logic u,
                                    input logic l, input logic [3:0] lv);
    int m;
    m = mods[d];
    if (l) return (int'(lv) < m) ? int'(lv) : 0;
    if (e) return u ? (cm[d] + 1) % m : (cm[d] + m - 1) % m;
    return cm[d];
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check state.
  task automatic step(input logic r, input logic e, input logic u, input logic l,
                      input logic [3:0] lv, input logic c);
    logic [3:0] qs [2];
    int         n [2];
    logic [3:0] cv, nv;
    bit         tce;
    reset = r; en = e; up = u; load = l; load_val = lv; mismatch_clr = c;
    #1;
    for (int d = 0; d < 2; d++) begin
      cv   = cm[d][3:0];
      n[d] = model_next(d, e, u, l, lv);
      nv   = n[d][3:0];
      tce  = e && !l && ((u && cm[d] == mods[d] - 1) || (!u && cm[d] == 0));
      if (r) begin
        chk($sformatf("j_rst[%0d]", d), j[d], 4'b0000);
        chk($sformatf("k_rst[%0d]", d), k[d], 4'b1111);
      end else begin
        chk($sformatf("j[%0d]", d), j[d], ~cv & nv);
        chk($sformatf("k[%0d]", d), k[d], cv & ~nv);
      end
      chk($sformatf("tc[%0d]", d), tc[d], tce);
      qs[d] = q_fb[d];
    end
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        cm[d] = 0;
        mm[d] = 1'b0;
      end else begin
        if (qs[d] !== cm[d][3:0]) mm[d] = 1'b1;
        else if (c) mm[d] = 1'b0;
        cm[d] = n[d];
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("count[%0d]", d), count[d], cm[d][3:0]);
      chk($sformatf("bank[%0d]", d), bank[d], cm[d][3:0]);
      chk($sformatf("mismatch[%0d]", d), mismatch[d], mm[d]);
    end
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    chk("reset_count", count[0], 4'd0);

    for (int i = 0; i < 12; i++) step(0, 1, 1, 0, 0, 0);
    chk("up12_count", count[0], 4'd2);

    step(0, 0, 0, 1, 4'd0, 0);
    en = 1'b1; up = 1'b0; load = 1'b0; #1;
    chk("down_wrap_j", j[0], 4'b1001);
    chk("down_wrap_k", k[0], 4'b0000);
    chk("down_wrap_tc", tc[0], 1'b1);
    step(0, 1, 0, 0, 0, 0);
    chk("down_wrap_count", count[0], 4'd9);

    step(0, 1, 1, 1, 4'd7, 0);
    chk("load7", count[0], 4'd7);
    step(0, 1, 1, 1, 4'd12, 0);
    chk("load12_clamp", count[0], 4'd0);
    chk("load12_mod16", count[1], 4'd12);

    step(0, 0, 1, 1, 4'd5, 0);
    fault = 4'b0010;
    step(0, 0, 1, 0, 0, 0);
    fault = 4'b0000;
    chk("fault_set", mismatch[0], 1'b1);
    step(0, 0, 1, 0, 0, 0);
    chk("fault_sticky", mismatch[0], 1'b1);
    step(0, 0, 1, 0, 0, 1);
    chk("fault_clear", mismatch[0], 1'b0);

    step(0, 0, 1, 1, 4'd6, 0);
    step(1, 1, 1, 0, 0, 0);
    chk("midreset_count", count[0], 4'd0);
    chk("midreset_bank", bank[0], 4'd0);
    step(0, 0, 1, 0, 0, 0);
    chk("postreset_mismatch", mismatch[0], 1'b0);

    step(0, 0, 1, 1, 4'd15, 0);
    en = 1'b1; up = 1'b1; load = 1'b0; #1;
    chk("m16_wrap_j", j[1], 4'b0000);
    chk("m16_wrap_k", k[1], 4'b1111);
    step(0, 1, 1, 0, 0, 0);
    chk("m16_wrap_count", count[1], 4'd0);

    for (int i = 0; i < 400; i++) begin
      fault = ($urandom_range(0, 29) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, 1'($urandom),
           $urandom_range(0, 9) == 0, 4'($urandom), $urandom_range(0, 7) == 0);
      fault = 4'd0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
